// File: rtl/spu_sram_reader.sv
// spu_sram_reader: reads a contiguous word block from two SRAM banks
// and streams it to the SPU. Optional macro: SPU_SRAM_READER_ABORT_EN.
module spu_sram_reader #(
    parameter int DATA_BITS    = 64,
    parameter int ADDR_BITS    = 10,
    parameter int LEN_BITS     = 11,
    parameter int READ_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cke,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [LEN_BITS-1:0]  length,
`ifdef SPU_SRAM_READER_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 mem_en,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [DATA_BITS-1:0] mem_rdata0,
    input  logic [DATA_BITS-1:0] mem_rdata1,
    output logic [DATA_BITS-1:0] m_data0,
    output logic [DATA_BITS-1:0] m_data1,
    output logic                 m_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_BITS-1:0] ADDR_ONE = 1;
    localparam logic [LEN_BITS-1:0]  LEN_ONE  = 1;

    state_t                  state;
    logic [LEN_BITS-1:0]     len_q;
    logic [LEN_BITS-1:0]     count;
    logic [READ_LATENCY-1:0] pipe;
    logic                    abort_hit;

`ifdef SPU_SRAM_READER_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // Control FSM: count holds the number of words issued so far,
    // mem_addr walks the block and wraps naturally at 2^ADDR_BITS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_en   <= 1'b0;
            mem_addr <= '0;
            len_q    <= '0;
            count    <= '0;
        end else if (cke) begin
            done <= 1'b0;
            if (abort_hit) begin
                mem_en <= 1'b0;
                busy   <= 1'b0;
                done   <= 1'b1;
                state  <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            if (length != '0) begin
                                len_q    <= length;
                                count    <= LEN_ONE;
                                mem_addr <= base_addr;
                                mem_en   <= 1'b1;
                                busy     <= 1'b1;
                                state    <= RUN;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (count == len_q) begin
                            mem_en <= 1'b0;
                            state  <= DRAIN;
                        end else begin
                            mem_addr <= mem_addr + ADDR_ONE;
                            count    <= count + LEN_ONE;
                        end
                    end
                    DRAIN: begin
                        if (!mem_en && (pipe == '0)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Issue pipeline tracks in-flight reads; its tail qualifies the
    // SRAM data into the registered output stream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe    <= '0;
            m_valid <= 1'b0;
            m_data0 <= '0;
            m_data1 <= '0;
        end else if (cke) begin
            m_data0 <= mem_rdata0;
            m_data1 <= mem_rdata1;
            if (abort_hit) begin
                pipe    <= '0;
                m_valid <= 1'b0;
            end else begin
                pipe[0] <= mem_en;
                for (int i = 1; i < READ_LATENCY; i++) begin
                    pipe[i] <= pipe[i-1];
                end
                m_valid <= pipe[READ_LATENCY-1];
            end
        end
    end

endmodule

// File: tb/tb_spu_sram_reader.sv
// tb_spu_sram_reader: directed table-driven bench for spu_sram_reader
// with a READ_LATENCY=2 SRAM model returning data0=addr, data1=~addr.
module tb_spu_sram_reader;

    localparam int AB = 10;
    localparam int LB = 11;
    localparam int DB = 64;
    localparam int RL = 2;

    logic          clk;
    logic          reset;
    logic          cke;
    logic          start;
    logic [AB-1:0] base_addr;
    logic [LB-1:0] length;
    logic          abort;
    logic          busy;
    logic          done;
    logic          mem_en;
    logic [AB-1:0] mem_addr;
    logic [DB-1:0] mem_rdata0;
    logic [DB-1:0] mem_rdata1;
    logic [DB-1:0] m_data0;
    logic [DB-1:0] m_data1;
    logic          m_valid;

    int checks;
    int errors;

    spu_sram_reader #(
        .DATA_BITS(DB),
        .ADDR_BITS(AB),
        .LEN_BITS(LB),
        .READ_LATENCY(RL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cke(cke),
        .start(start),
        .base_addr(base_addr),
        .length(length),
`ifdef SPU_SRAM_READER_ABORT_EN
        .abort(abort),
`endif
        .busy(busy),
        .done(done),
        .mem_en(mem_en),
        .mem_addr(mem_addr),
        .mem_rdata0(mem_rdata0),
        .mem_rdata1(mem_rdata1),
        .m_data0(m_data0),
        .m_data1(m_data1),
        .m_valid(m_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: address sampled on a cke edge appears RL cke edges later.
    logic [AB-1:0] dl0;
    logic [AB-1:0] dl1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dl0 <= '0;
            dl1 <= '0;
        end else if (cke) begin
            dl0 <= mem_addr;
            dl1 <= dl0;
        end
    end
    assign mem_rdata0 = {54'b0, dl1};
    assign mem_rdata1 = ~{54'b0, dl1};

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One transfer: entered at a negedge (cycle 0, start driven here),
    // returns at the negedge of the cke-qualified done cycle.
    task automatic xfer(input string tag, input logic [AB-1:0] base,
                        input logic [LB-1:0] len, input bit tog,
                        input int mid, input int exp_lat, input int exp_done);
        int ones, nissue, nvalid, issue_one, valid_one, done_one;
        int busy_err, addr_err, data_err;
        bit after_last, got_done;
        logic [AB-1:0] ea;
        ones = 0; nissue = 0; nvalid = 0;
        issue_one = -1; valid_one = -1; done_one = -1;
        busy_err = 0; addr_err = 0; data_err = 0;
        after_last = 0; got_done = 0;
        start = 1'b1;
        base_addr = base;
        length = len;
        cke = 1'b1;
        abort = 1'b0;
        for (int k = 1; k < 200 && !got_done; k++) begin
            @(negedge clk);
            cke = tog ? (k % 2 == 0) : 1'b1;
            if (k == mid) begin
                start = 1'b1;
                base_addr = 10'h100;
                length = 11'd5;
            end else begin
                start = 1'b0;
            end
            if (cke) ones++;
            if (after_last) begin
                after_last = 0;
                chk_b({tag, " done_after_last"}, done, 1'b1);
                chk_b({tag, " busy_at_done"}, busy, 1'b0);
            end
            if (len == 0) begin
                if (busy !== 1'b0) busy_err++;
            end else if (!done && busy !== 1'b1) begin
                busy_err++;
            end
            if (cke) begin
                if (mem_en) begin
                    if (nissue == 0) issue_one = ones;
                    ea = base + AB'(nissue);
                    if (mem_addr !== ea) addr_err++;
                    nissue++;
                end
                if (m_valid) begin
                    if (nvalid == 0) valid_one = ones;
                    ea = base + AB'(nvalid);
                    if (m_data0 !== {54'b0, ea}) data_err++;
                    if (m_data1 !== ~{54'b0, ea}) data_err++;
                    nvalid++;
                    if (nvalid == int'(len)) after_last = 1;
                end
                if (done) begin
                    got_done = 1;
                    done_one = ones;
                end
            end
        end
        chk_b({tag, " done_seen"}, got_done, 1'b1);
        chk_i({tag, " issues"}, nissue, int'(len));
        chk_i({tag, " valids"}, nvalid, int'(len));
        chk_i({tag, " addr_errs"}, addr_err, 0);
        chk_i({tag, " data_errs"}, data_err, 0);
        chk_i({tag, " busy_errs"}, busy_err, 0);
        chk_i({tag, " done_pos"}, done_one, exp_done);
        if (len != 0) chk_i({tag, " latency"}, valid_one - issue_one, exp_lat);
    endtask

    typedef struct {
        string         tag;
        logic [AB-1:0] base;
        logic [LB-1:0] len;
        bit            tog;
        int            mid;
        bit            chain;
        int            exp_lat;
        int            exp_done;
    } vec_t;

    vec_t vecs[7];

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{"basic8",  10'h010, 11'd8,  1'b0, 0, 1'b0, 3, 12};
        vecs[1] = '{"len0",    10'h000, 11'd0,  1'b0, 0, 1'b0, 3, 1};
        vecs[2] = '{"wrap4",   10'h3FE, 11'd4,  1'b0, 0, 1'b0, 3, 8};
        vecs[3] = '{"cke16",   10'h020, 11'd16, 1'b1, 0, 1'b0, 3, 20};
        vecs[4] = '{"len1",    10'h3FF, 11'd1,  1'b0, 0, 1'b0, 3, 5};
        vecs[5] = '{"midstart",10'h040, 11'd8,  1'b0, 3, 1'b0, 3, 12};
        vecs[6] = '{"donestart",10'h200,11'd2,  1'b0, 0, 1'b1, 3, 6};

        reset = 1'b1;
        cke = 1'b0;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        chk_b("rst busy", busy, 1'b0);
        chk_b("rst done", done, 1'b0);
        chk_b("rst mem_en", mem_en, 1'b0);
        chk_b("rst m_valid", m_valid, 1'b0);
        chk_w("rst mem_addr", 64'(mem_addr), 64'h0);
        chk_w("rst m_data0", m_data0, 64'h0);
        reset = 1'b0;
        cke = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            if (!vecs[i].chain) begin
                start = 1'b0;
                cke = 1'b1;
                repeat (2) @(negedge clk);
            end
            xfer(vecs[i].tag, vecs[i].base, vecs[i].len, vecs[i].tog,
                 vecs[i].mid, vecs[i].exp_lat, vecs[i].exp_done);
        end

        // Reset while word 3 is being issued.
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        base_addr = 10'h050;
        length = 11'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk_w("mid addr", 64'(mem_addr), 64'h053);
        chk_b("mid valid", m_valid, 1'b1);
        reset = 1'b1;
        #1;
        chk_b("rstmid m_valid", m_valid, 1'b0);
        chk_b("rstmid busy", busy, 1'b0);
        chk_b("rstmid mem_en", mem_en, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        begin
            int ndone;
            ndone = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (done || m_valid) ndone++;
            end
            chk_i("rstmid no_done", ndone, 0);
        end
        xfer("postrst", 10'h060, 11'd3, 1'b0, 0, 3, 7);

`ifdef SPU_SRAM_READER_ABORT_EN
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        base_addr = 10'h070;
        length = 11'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk_b("abort pre_valid", m_valid, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_b("abort m_valid", m_valid, 1'b0);
        chk_b("abort done", done, 1'b1);
        chk_b("abort mem_en", mem_en, 1'b0);
        chk_b("abort busy", busy, 1'b0);
        @(negedge clk);
        chk_b("abort done_end", done, 1'b0);
        chk_b("abort flushed", m_valid, 1'b0);
        xfer("postabort", 10'h080, 11'd2, 1'b0, 0, 3, 6);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
